// File: rtl/ddr3_arb_pkg.sv
// Shared types and constants for the DDR3 read/write burst arbiter.
// The optional watchdog is enabled with `define DDR3_ARB_TIMEOUT_EN.
package ddr3_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_START,
        WR_WAIT,
        RD_START,
        RD_WAIT
    } arb_state_t;

    typedef enum logic {
        WRITE,
        READ
    } grant_t;

    // One BL8 access per 128-bit beat advances app_addr by 8.
    localparam int unsigned ADDR_STEP = 8;

endpackage

// File: rtl/ddr3_addr_ptr.sv
// Wrapping burst address pointer over one frame-buffer region, with a
// clear request that is deferred to burst completion while the side is active.
module ddr3_addr_ptr
    import ddr3_arb_pkg::*;
#(
    parameter int unsigned             ADDR_WIDTH  = 28,
    parameter int unsigned             BURST_LEN   = 64,
    parameter logic [ADDR_WIDTH-1:0]   BASE        = '0,
    parameter int unsigned             REGION_SIZE = 32'h0200000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  active,
    input  logic                  adv,
    input  logic                  clr,
    output logic [ADDR_WIDTH-1:0] addr
);

    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(BURST_LEN * ADDR_STEP);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(REGION_SIZE - BURST_LEN * ADDR_STEP);

    logic [ADDR_WIDTH-1:0] offset;
    logic                  pending;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            offset  <= '0;
            pending <= 1'b0;
        end else if (adv) begin
            // A pending or coincident clear takes priority over the increment.
            offset  <= (clr || pending) ? '0 : ((offset == LAST) ? '0 : offset + STEP);
            pending <= 1'b0;
        end else if (clr) begin
            if (active) begin
                pending <= 1'b1;
            end else begin
                offset  <= '0;
                pending <= 1'b0;
            end
        end else if (pending && !active) begin
            // Burst ended without completing (watchdog abort): apply the clear now.
            offset  <= '0;
            pending <= 1'b0;
        end
    end

    assign addr = BASE + offset;

endmodule

// File: rtl/ddr3_rw_arbiter.sv
// Round-robin scheduler of write/read bursts onto the single MIG user port.
// Optional burst watchdog: `define DDR3_ARB_TIMEOUT_EN.
module ddr3_rw_arbiter
    import ddr3_arb_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH    = 28,
    parameter int unsigned           BURST_LEN     = 64,
    parameter logic [ADDR_WIDTH-1:0] WR_BASE       = '0,
    parameter logic [ADDR_WIDTH-1:0] RD_BASE       = '0,
    parameter int unsigned           REGION_SIZE   = 32'h0200000,
    parameter int unsigned           FIFO_CNT_W    = 10,
    parameter int unsigned           RD_FIFO_DEPTH = 512,
    parameter int unsigned           TIMEOUT       = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init_calib_complete,
    input  logic [FIFO_CNT_W-1:0] wr_fifo_cnt,
    input  logic [FIFO_CNT_W-1:0] rd_fifo_cnt,
    input  logic                  wr_addr_clr,
    input  logic                  rd_addr_clr,
    output logic                  wr_burst_start,
    output logic [ADDR_WIDTH-1:0] wr_burst_len,
    output logic [ADDR_WIDTH-1:0] wr_burst_addr,
    input  logic                  wr_burst_done,
    output logic                  rd_burst_start,
    output logic [ADDR_WIDTH-1:0] rd_burst_len,
    output logic [ADDR_WIDTH-1:0] rd_burst_addr,
    input  logic                  rd_burst_done,
    output logic                  mig_sel,
    output logic                  arb_busy,
    output logic                  timeout_err
);

    localparam logic [FIFO_CNT_W-1:0] WR_THRESH = FIFO_CNT_W'(BURST_LEN);
    localparam logic [FIFO_CNT_W-1:0] RD_THRESH = FIFO_CNT_W'(RD_FIFO_DEPTH - BURST_LEN);

    arb_state_t state;
    grant_t     last_grant;
    logic       wr_req, rd_req;
    logic       wr_active, rd_active, wr_adv, rd_adv;
    logic       tmo_hit;

    assign wr_req    = (wr_fifo_cnt >= WR_THRESH);
    assign rd_req    = (rd_fifo_cnt <= RD_THRESH);
    assign wr_active = (state == WR_START) || (state == WR_WAIT);
    assign rd_active = (state == RD_START) || (state == RD_WAIT);
    assign wr_adv    = (state == WR_WAIT) && wr_burst_done;
    assign rd_adv    = (state == RD_WAIT) && rd_burst_done;

    assign wr_burst_len = ADDR_WIDTH'(BURST_LEN);
    assign rd_burst_len = ADDR_WIDTH'(BURST_LEN);

`ifdef DDR3_ARB_TIMEOUT_EN
    localparam int unsigned TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_flag;

    assign tmo_hit     = (tmo_cnt == TMO_W'(TIMEOUT - 1));
    assign timeout_err = tmo_flag;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmo_cnt  <= '0;
            tmo_flag <= 1'b0;
        end else begin
            tmo_cnt <= (state == WR_WAIT || state == RD_WAIT) ? tmo_cnt + TMO_W'(1) : '0;
            if ((state == WR_WAIT && !wr_burst_done && tmo_hit) ||
                (state == RD_WAIT && !rd_burst_done && tmo_hit))
                tmo_flag <= 1'b1;
        end
    end
`else
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            last_grant     <= READ;
            wr_burst_start <= 1'b0;
            rd_burst_start <= 1'b0;
            mig_sel        <= 1'b0;
            arb_busy       <= 1'b0;
        end else begin
            wr_burst_start <= 1'b0;
            rd_burst_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (init_calib_complete) begin
                        if (wr_req && (!rd_req || last_grant == READ)) begin
                            state          <= WR_START;
                            wr_burst_start <= 1'b1;
                            mig_sel        <= 1'b1;
                            arb_busy       <= 1'b1;
                        end else if (rd_req) begin
                            state          <= RD_START;
                            rd_burst_start <= 1'b1;
                            mig_sel        <= 1'b0;
                            arb_busy       <= 1'b1;
                        end
                    end
                end
                WR_START: begin
                    state      <= WR_WAIT;
                    last_grant <= WRITE;
                end
                WR_WAIT: begin
                    if (wr_burst_done || tmo_hit) begin
                        state    <= IDLE;
                        arb_busy <= 1'b0;
                    end
                end
                RD_START: begin
                    state      <= RD_WAIT;
                    last_grant <= READ;
                end
                RD_WAIT: begin
                    if (rd_burst_done || tmo_hit) begin
                        state    <= IDLE;
                        arb_busy <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    arb_busy <= 1'b0;
                end
            endcase
        end
    end

    ddr3_addr_ptr #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BURST_LEN  (BURST_LEN),
        .BASE       (WR_BASE),
        .REGION_SIZE(REGION_SIZE)
    ) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .active(wr_active),
        .adv   (wr_adv),
        .clr   (wr_addr_clr),
        .addr  (wr_burst_addr)
    );

    ddr3_addr_ptr #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BURST_LEN  (BURST_LEN),
        .BASE       (RD_BASE),
        .REGION_SIZE(REGION_SIZE)
    ) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .active(rd_active),
        .adv   (rd_adv),
        .clr   (rd_addr_clr),
        .addr  (rd_burst_addr)
    );

endmodule

// File: tb/tb_ddr3_rw_arbiter.sv
// Scoreboard bench for ddr3_rw_arbiter: a reference model predicts grant order and
// burst addresses; a monitor checks every start pulse against the queued prediction.
module tb_ddr3_rw_arbiter;

    localparam int AW     = 28;
    localparam int BL     = 64;
    localparam int REGION = 2048;
    localparam int DEPTH  = 512;
    localparam int TMO    = 16;
    localparam int CW     = 10;
    localparam int STEP   = BL * 8;
    localparam logic [AW-1:0] WRB = 28'h0000000;
    localparam logic [AW-1:0] RDB = 28'h0100000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          calib = 1'b0;
    logic [CW-1:0] wr_cnt = '0;
    logic [CW-1:0] rd_cnt = CW'(DEPTH);
    logic          clr_stim_wr = 1'b0, clr_stim_rd = 1'b0, clr_resp = 1'b0;
    logic          wr_clr, rd_clr;
    logic          wr_burst_done = 1'b0, rd_burst_done = 1'b0;
    logic          wr_burst_start, rd_burst_start, mig_sel, arb_busy, timeout_err;
    logic [AW-1:0] wr_burst_len, wr_burst_addr, rd_burst_len, rd_burst_addr;

    assign wr_clr = clr_stim_wr | clr_resp;
    assign rd_clr = clr_stim_rd;

    always #5 clk = ~clk;

    ddr3_rw_arbiter #(
        .ADDR_WIDTH   (AW),
        .BURST_LEN    (BL),
        .WR_BASE      (WRB),
        .RD_BASE      (RDB),
        .REGION_SIZE  (REGION),
        .FIFO_CNT_W   (CW),
        .RD_FIFO_DEPTH(DEPTH),
        .TIMEOUT      (TMO)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .init_calib_complete(calib),
        .wr_fifo_cnt        (wr_cnt),
        .rd_fifo_cnt        (rd_cnt),
        .wr_addr_clr        (wr_clr),
        .rd_addr_clr        (rd_clr),
        .wr_burst_start     (wr_burst_start),
        .wr_burst_len       (wr_burst_len),
        .wr_burst_addr      (wr_burst_addr),
        .wr_burst_done      (wr_burst_done),
        .rd_burst_start     (rd_burst_start),
        .rd_burst_len       (rd_burst_len),
        .rd_burst_addr      (rd_burst_addr),
        .rd_burst_done      (rd_burst_done),
        .mig_sel            (mig_sel),
        .arb_busy           (arb_busy),
        .timeout_err        (timeout_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void check(string name, longint act, longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: per-side offsets, last granted side, expected start queue.
    typedef struct packed {
        logic          is_wr;
        logic [AW-1:0] addr;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned m_off[2];   // index 1 = write, 0 = read
    bit          m_last_wr;

    function automatic void model_reset();
        m_off[0]  = 0;
        m_off[1]  = 0;
        m_last_wr = 1'b0;
    endfunction

    function automatic void push_exp(bit is_wr);
        exp_t e;
        e.is_wr = is_wr;
        e.addr  = (is_wr ? WRB : RDB) + AW'(m_off[is_wr]);
        exp_q.push_back(e);
    endfunction

    function automatic void advance(bit is_wr, bit clr);
        m_off[is_wr] = clr ? 0 : (m_off[is_wr] + STEP) % REGION;
    endfunction

    // Engine responder: done pulse 2..6 cycles after start, with random
    // spurious done pulses on the idle side.
    int wr_cd = 0, rd_cd = 0;
    bit hold_rd = 1'b0, clr_at_done = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            wr_burst_done = 1'b0;
            rd_burst_done = 1'b0;
            clr_resp      = 1'b0;
            if (!rst_n) begin
                wr_cd = 0;
                rd_cd = 0;
            end else begin
                if (wr_burst_start) wr_cd = $urandom_range(2, 6);
                else if (wr_cd > 0) begin
                    wr_cd--;
                    if (wr_cd == 0) begin
                        wr_burst_done = 1'b1;
                        rd_burst_done = 1'($urandom_range(0, 1));
                        clr_resp      = clr_at_done;
                    end
                end
                if (rd_burst_start) begin
                    if (!hold_rd) rd_cd = $urandom_range(2, 6);
                end else if (rd_cd > 0) begin
                    rd_cd--;
                    if (rd_cd == 0) begin
                        rd_burst_done = 1'b1;
                        wr_burst_done = 1'($urandom_range(0, 1));
                    end
                end
            end
        end
    end

    // Monitor: every start pulse is matched against the next prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (wr_burst_start || rd_burst_start)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_start", {wr_burst_start, rd_burst_start}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("grant_side", {wr_burst_start, rd_burst_start}, e.is_wr ? 2 : 1);
                    check("burst_addr", e.is_wr ? wr_burst_addr : rd_burst_addr, e.addr);
                    check("mig_sel", mig_sel, e.is_wr);
                    check("burst_len", e.is_wr ? wr_burst_len : rd_burst_len, BL);
                end
            end
        end
    end

    task automatic wait_idle();
        int k = 0;
        do begin
            @(negedge clk);
            clr_stim_wr = 1'b0;
            k++;
        end while ((arb_busy || wr_cd != 0 || rd_cd != 0) && k < 80);
        if (k >= 80) check("idle_timeout", arb_busy, 0);
        @(negedge clk);
    endtask

    task automatic pulse_clr(bit is_wr);
        @(negedge clk);
        if (is_wr) clr_stim_wr = 1'b1; else clr_stim_rd = 1'b1;
        @(negedge clk);
        clr_stim_wr = 1'b0;
        clr_stim_rd = 1'b0;
        m_off[is_wr] = 0;
    endtask

    // Hold the given FIFO levels until n starts are seen, then release.
    task automatic run_phase(int wc, int rc, int n, bit clr_mid, bit clr_done);
        bit wreq, rreq, g;
        int seen, budget, idle_starts;
        wreq = (wc >= BL);
        rreq = (rc <= DEPTH - BL);
        clr_at_done = clr_done;
        wr_cnt = CW'(wc);
        rd_cnt = CW'(rc);
        if (!wreq && !rreq) begin
            idle_starts = 0;
            repeat (8) begin
                @(negedge clk);
                if (wr_burst_start || rd_burst_start) idle_starts++;
            end
            check("no_request_idle", idle_starts, 0);
            wr_cnt = '0;
            rd_cnt = CW'(DEPTH);
            clr_at_done = 1'b0;
            return;
        end
        for (int i = 0; i < n; i++) begin
            g = wreq && (!rreq || !m_last_wr);
            push_exp(g);
            advance(g, g && (clr_mid || clr_done));
            m_last_wr = g;
        end
        seen = 0;
        budget = 0;
        while (seen < n && budget < 30 * n) begin
            @(negedge clk);
            budget++;
            clr_stim_wr = 1'b0;
            if (wr_burst_start || rd_burst_start) begin
                seen++;
                if (clr_mid && wr_burst_start) clr_stim_wr = 1'b1;
                if (seen == n) begin
                    wr_cnt = '0;
                    rd_cnt = CW'(DEPTH);
                end
            end
        end
        if (seen < n) check("start_timeout", seen, n);
        wr_cnt = '0;
        rd_cnt = CW'(DEPTH);
        wait_idle();
        clr_at_done = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, cnt;
        model_reset();
        repeat (4) @(negedge clk);
        check("rst_wr_start", wr_burst_start, 0);
        check("rst_rd_start", rd_burst_start, 0);
        check("rst_mig_sel", mig_sel, 0);
        check("rst_busy", arb_busy, 0);
        check("rst_wr_addr", wr_burst_addr, WRB);
        check("rst_rd_addr", rd_burst_addr, RDB);
        check("rst_timeout_err", timeout_err, 0);
        rst_n = 1'b1;

        // Calibration gate, then start one cycle after the request is seen.
        wr_cnt = CW'(100);
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (wr_burst_start || rd_burst_start) cnt++;
        end
        check("calib_gate", cnt, 0);
        push_exp(1'b1);
        advance(1'b1, 1'b0);
        m_last_wr = 1'b1;
        calib = 1'b1;
        @(negedge clk);
        check("calib_start_latency", wr_burst_start, 1);
        wr_cnt = '0;
        wait_idle();

        run_phase(200, 0, 4, 1'b0, 1'b0);      // contention: alternation
        run_phase(200, DEPTH, 5, 1'b0, 1'b0);  // write-only, wraps
        run_phase(200, DEPTH, 1, 1'b1, 1'b0);  // clear during burst
        run_phase(200, DEPTH, 1, 1'b0, 1'b0);
        run_phase(200, DEPTH, 1, 1'b0, 1'b1);  // clear coincident with done
        run_phase(200, DEPTH, 2, 1'b0, 1'b0);
        run_phase(0, 449, 1, 1'b0, 1'b0);      // thresholds
        run_phase(0, 448, 1, 1'b0, 1'b0);
        run_phase(63, DEPTH, 1, 1'b0, 1'b0);
        run_phase(64, DEPTH, 1, 1'b0, 1'b0);
        run_phase(0, 0, 2, 1'b0, 1'b0);
        pulse_clr(1'b0);                        // idle clears
        run_phase(0, 0, 1, 1'b0, 1'b0);
        run_phase(200, DEPTH, 2, 1'b0, 1'b0);
        pulse_clr(1'b1);
        run_phase(200, DEPTH, 1, 1'b0, 1'b0);

        for (int i = 0; i < 14; i++) begin
            if ($urandom_range(0, 4) == 0) pulse_clr(1'($urandom_range(0, 1)));
            run_phase($urandom_range(56, 220), $urandom_range(380, 470), $urandom_range(1, 3),
                      ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        end

        // Reset in the middle of a write burst.
        run_phase(200, DEPTH, 1, 1'b0, 1'b0);
        wr_cnt = CW'(200);
        push_exp(1'b1);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!wr_burst_start && k < 40);
        if (k >= 40) check("reset_burst_start", wr_burst_start, 1);
        wr_cnt = '0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_busy", arb_busy, 0);
        check("midrst_wr_addr", wr_burst_addr, WRB);
        check("midrst_rd_addr", rd_burst_addr, RDB);
        rst_n = 1'b1;
        model_reset();
        run_phase(200, 0, 4, 1'b0, 1'b0);

`ifdef DDR3_ARB_TIMEOUT_EN
        hold_rd = 1'b1;
        run_phase(0, DEPTH, 0, 1'b0, 1'b0);
        rd_cnt = '0;
        push_exp(1'b0);                         // aborted: pointer must not advance
        m_last_wr = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!rd_burst_start && k < 40);
        rd_cnt = CW'(DEPTH);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (arb_busy && k < 100);
        check("timeout_cycles", k, TMO + 1);
        check("timeout_err_set", timeout_err, 1);
        hold_rd = 1'b0;
        wait_idle();
        run_phase(0, 0, 1, 1'b0, 1'b0);
        check("timeout_err_sticky", timeout_err, 1);
`else
        check("timeout_err_tied", timeout_err, 0);
`endif

        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
